// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin scheduler sharing one UART transmitter among NREQ
//            byte-stream requesters. One byte at a time is issued to the UART
//            core, then the scheduler waits for tx_busy to rise and fall
//            before arbitrating again.
// Optional : UART_SCHED_LOCK_EN - packet lock. A requester whose byte is
//            accepted with req_last=0 keeps the transmitter until it sends a
//            byte with req_last=1 (or the attempt times out).
// Ports    : clk_i          system clock, rising edge
//            rst_ni         asynchronous active-low reset
//            req_valid_i    per-requester byte pending
//            req_data_i     per-requester byte, requester i in [8i+7:8i]
//            req_last_i     per-requester end-of-packet (lock build only)
//            req_ready_o    one-cycle pulse, byte of requester consumed
//            grant_o        one-hot owner of current/last transfer
//            tx_wr_o        one-cycle write strobe to the UART core
//            tx_data_o      byte to the UART core, held until next issue
//            tx_busy_i      UART core busy
//            sched_busy_o   high whenever the scheduler is not arbitrating
//            err_nobusy_o   one-cycle pulse, tx_busy never rose after tx_wr
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
   parameter int NREQ      = 2,
   parameter int BUSY_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [8*NREQ-1:0] req_data_i,
   input  logic [NREQ-1:0]   req_last_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [NREQ-1:0]   grant_o,
   output logic              tx_wr_o,
   output logic [7:0]        tx_data_o,
   input  logic              tx_busy_i,
   output logic              sched_busy_o,
   output logic              err_nobusy_o
);

   localparam int         PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] C_BUSY_WAIT = 4'(BUSY_WAIT);

   typedef enum logic [1:0] {
      ST_ARB       = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] ready_q, ready_d;
   logic [7:0]      data_q, data_d;
   logic            wr_q, wr_d;
   logic            sbusy_q, sbusy_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] elig;
   logic            found;
   logic [PW-1:0]   win;
   logic [NREQ-1:0] win_oh;
   logic [7:0]      win_data;
   int              cand;

`ifdef UART_SCHED_LOCK_EN
   logic            lock_vld_q, lock_vld_d;
   logic [PW-1:0]   lock_id_q, lock_id_d;
   logic [NREQ-1:0] lock_oh;

   // While a packet is in progress only its owner may be selected.
   always_comb begin
      lock_oh          = '0;
      lock_oh[lock_id_q] = 1'b1;
      elig             = lock_vld_q ? (req_valid_i & lock_oh) : req_valid_i;
   end
`else
   logic unused_last;
   assign elig        = req_valid_i;
   assign unused_last = ^req_last_i;
`endif

   // Round-robin search starting one past the last winner.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!found && elig[PW'(cand)]) begin
            found = 1'b1;
            win   = PW'(cand);
         end
      end
      win_oh      = '0;
      win_oh[win] = 1'b1;
      win_data    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) win_data = req_data_i[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      data_d  = data_q;
      ready_d = '0;
      wr_d    = 1'b0;
      err_d   = 1'b0;
`ifdef UART_SCHED_LOCK_EN
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
`endif
      case (state_q)
         ST_ARB: begin
            if (!tx_busy_i && found) begin
               state_d = ST_ISSUE;
               grant_d = win_oh;
               data_d  = win_data;
               ptr_d   = win;
               wr_d    = 1'b1;
               ready_d = win_oh;
               cnt_d   = 4'd0;
`ifdef UART_SCHED_LOCK_EN
               lock_vld_d = ~req_last_i[win];
               lock_id_d  = win;
`endif
            end
         end
         ST_ISSUE: begin
            // The busy window is measured from the tx_wr cycle itself,
            // so the ISSUE cycle is the first counted cycle.
            cnt_d   = 4'd1;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            cnt_d = cnt_q + 4'd1;
            if (tx_busy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_d >= C_BUSY_WAIT) begin
               err_d   = 1'b1;
               state_d = ST_ARB;
`ifdef UART_SCHED_LOCK_EN
               lock_vld_d = 1'b0;
`endif
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy_i) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
      sbusy_d = (state_d != ST_ARB);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_ARB;
         ptr_q   <= PW'(NREQ - 1);
         cnt_q   <= 4'd0;
         grant_q <= '0;
         data_q  <= 8'h00;
         ready_q <= '0;
         wr_q    <= 1'b0;
         sbusy_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         wr_q    <= wr_d;
         sbusy_q <= sbusy_d;
         err_q   <= err_d;
      end
   end

`ifdef UART_SCHED_LOCK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_vld_q <= 1'b0;
         lock_id_q  <= '0;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
      end
   end
`endif

   assign req_ready_o  = ready_q;
   assign grant_o      = grant_q;
   assign tx_wr_o      = wr_q;
   assign tx_data_o    = data_q;
   assign sched_busy_o = sbusy_q;
   assign err_nobusy_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed self-checking bench for uart_tx_scheduler (NREQ=2,
//            BUSY_WAIT=4). A small UART-core model raises tx_busy for a
//            programmable frame length starting one cycle after tx_wr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_data = 16'h0000;
   logic [1:0]  req_last = 2'b00;
   logic [1:0]  req_ready;
   logic [1:0]  grant;
   logic        tx_wr;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        sched_busy;
   logic        err_nobusy;

   int n_vec = 0;
   int n_err = 0;

   // UART core model
   logic model_en = 1'b1;
   logic forced_busy = 1'b0;
   int   frame_len = 10;
   int   bc = 0;

   // transmit log and protocol monitor
   logic [7:0] log_d [0:255];
   logic [1:0] log_g [0:255];
   int         log_n = 0;
   logic       prev_wr = 1'b0;
   int         wr_viol = 0;
   int         ready_viol = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NREQ(2), .BUSY_WAIT(4)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_last_i   (req_last),
      .req_ready_o  (req_ready),
      .grant_o      (grant),
      .tx_wr_o      (tx_wr),
      .tx_data_o    (tx_data),
      .tx_busy_i    (tx_busy),
      .sched_busy_o (sched_busy),
      .err_nobusy_o (err_nobusy)
   );

   always @(posedge clk) begin
      if (tx_wr && model_en) bc <= frame_len;
      else if (bc > 0)       bc <= bc - 1;
   end
   assign tx_busy = model_en ? (bc != 0) : forced_busy;

   always @(negedge clk) begin
      if (tx_wr) begin
         log_d[log_n[7:0]] = tx_data;
         log_g[log_n[7:0]] = grant;
         log_n = log_n + 1;
      end
      if (tx_wr && prev_wr) wr_viol = wr_viol + 1;
      if (req_ready !== (tx_wr ? grant : 2'b00)) ready_viol = ready_viol + 1;
      prev_wr = tx_wr;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits at negedges for tx_wr; ok=0 if budget expires.
   task automatic wait_tx_wr(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_wr) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!sched_busy && !tx_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b expected 00", grant); end
      n_vec++; if (tx_wr !== 1'b0) begin n_err++; $display("FAIL reset_tx_wr: got %b expected 0", tx_wr); end
      n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      n_vec++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL reset_sched_busy: got %b expected 0", sched_busy); end
      n_vec++; if (err_nobusy !== 1'b0) begin n_err++; $display("FAIL reset_err_nobusy: got %b expected 0", err_nobusy); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int  base;
      bit  ok;
      logic [7:0] exp_d [0:3];
      logic [1:0] exp_g [0:3];
      exp_d[0] = 8'hA0; exp_d[1] = 8'hB0; exp_d[2] = 8'hA0; exp_d[3] = 8'hB0;
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      frame_len = 3;
      base = log_n;
      req_data  = {8'hB0, 8'hA0};
      req_valid = 2'b11;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (log_n >= base + 4) begin ok = 1'b1; break; end
      end
      req_valid = 2'b00;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rr_timeout: got %0d bytes expected 4", log_n - base); end
      else begin
         for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (log_d[base+j] !== exp_d[j]) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", j, log_d[base+j], exp_d[j]); end
            n_vec++;
            if (log_g[base+j] !== exp_g[j]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", j, log_g[base+j], exp_g[j]); end
         end
      end
      wait_idle(100, ok);
   endtask

   task automatic test_single();
      bit ok;
      frame_len = 10;
      @(negedge clk);
      req_data[7:0] = 8'h41;
      req_valid     = 2'b01;
      // next cycle after the ARB decision cycle is ISSUE
      @(negedge clk);
      req_valid = 2'b00;
      n_vec++; if (tx_wr !== 1'b1) begin n_err++; $display("FAIL single_tx_wr: got %b expected 1", tx_wr); end
      n_vec++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL single_tx_data: got %h expected 41", tx_data); end
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_req_ready: got %b expected 01", req_ready); end
      n_vec++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b expected 01", grant); end
      @(negedge clk);
      n_vec++; if (tx_wr !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL single_pulse_width: got wr=%b ready=%b expected 0/00", tx_wr, req_ready); end
      // tx_busy high for cycles T+1..T+10, first low at T+11
      repeat (10) @(negedge clk);
      n_vec++; if (sched_busy !== 1'b1 || tx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_tail: got sched_busy=%b tx_busy=%b expected 1/0", sched_busy, tx_busy); end
      @(negedge clk);
      n_vec++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL single_sched_idle: got %b expected 0", sched_busy); end
      n_vec++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant_held: got %b expected 01", grant); end
      wait_idle(50, ok);
   endtask

   task automatic test_packet();
      int  base;
      int  idx;
      bit  ok;
      logic [7:0] bytes0 [0:2];
      logic [7:0] exp_d [0:3];
      bytes0[0] = 8'h10; bytes0[1] = 8'h11; bytes0[2] = 8'h12;
`ifdef UART_SCHED_LOCK_EN
      exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12; exp_d[3] = 8'h20;
`else
      exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11; exp_d[3] = 8'h20;
`endif
      do_reset();
      frame_len = 3;
      idx = 0;
      base = log_n;
      req_data  = {8'h20, bytes0[0]};
      req_last  = 2'b10;
      req_valid = 2'b11;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            idx = idx + 1;
            if (idx < 3) begin
               req_data[7:0] = bytes0[idx];
               req_last[0]   = (idx == 2);
            end else begin
               req_valid[0] = 1'b0;
            end
         end
         if (log_n >= base + 4) begin ok = 1'b1; break; end
      end
      req_valid = 2'b00;
      req_last  = 2'b00;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL pkt_timeout: got %0d bytes expected 4", log_n - base); end
      else begin
         for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (log_d[base+j] !== exp_d[j]) begin n_err++; $display("FAIL pkt_order[%0d]: got %h expected %h", j, log_d[base+j], exp_d[j]); end
         end
      end
      wait_idle(100, ok);
   endtask

   task automatic test_nobusy();
      bit ok;
      bit early;
      model_en    = 1'b0;
      forced_busy = 1'b0;
      req_data[7:0] = 8'h55;
      req_valid     = 2'b01;
      wait_tx_wr(20, ok);
      req_valid = 2'b00;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL nobusy_issue: got no tx_wr expected tx_wr"); end
      early = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (err_nobusy !== 1'b0) early = 1'b1;
      end
      n_vec++; if (early) begin n_err++; $display("FAIL nobusy_early: got err pulse before T+4 expected none"); end
      @(negedge clk);
      n_vec++; if (err_nobusy !== 1'b1) begin n_err++; $display("FAIL nobusy_err: got %b expected 1", err_nobusy); end
      n_vec++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL nobusy_arb: got sched_busy=%b expected 0", sched_busy); end
      model_en      = 1'b1;
      frame_len     = 3;
      req_data[7:0] = 8'h66;
      req_valid     = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      n_vec++; if (err_nobusy !== 1'b0) begin n_err++; $display("FAIL nobusy_pulse_width: got %b expected 0", err_nobusy); end
      n_vec++; if (tx_wr !== 1'b1 || tx_data !== 8'h66) begin n_err++; $display("FAIL nobusy_next: got wr=%b data=%h expected 1/66", tx_wr, tx_data); end
      wait_idle(50, ok);
   endtask

   task automatic test_async_reset();
      bit   ok;
      bit   seen;
      logic last_busy;
      do_reset();
      model_en  = 1'b1;
      frame_len = 10;
      req_data  = {8'hB0, 8'hA0};
      req_valid = 2'b11;
      wait_tx_wr(20, ok);
      n_vec++;
      if (!ok || grant !== 2'b01) begin n_err++; $display("FAIL arst_first: got ok=%b grant=%b expected 1/01", ok, grant); end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({grant, tx_wr, tx_data, req_ready, sched_busy, err_nobusy} !== 15'h0) begin
         n_err++;
         $display("FAIL arst_outputs: got grant=%b wr=%b data=%h ready=%b sbusy=%b err=%b expected all 0",
                  grant, tx_wr, tx_data, req_ready, sched_busy, err_nobusy);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_busy = tx_busy;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_wr) begin seen = 1'b1; break; end
         last_busy = tx_busy;
      end
      req_valid = 2'b00;
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL arst_reissue: got no tx_wr expected tx_wr"); end
      else begin
         n_vec++; if (grant !== 2'b01) begin n_err++; $display("FAIL arst_grant: got %b expected 01", grant); end
         n_vec++; if (tx_data !== 8'hA0) begin n_err++; $display("FAIL arst_data: got %h expected A0", tx_data); end
         n_vec++; if (last_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy_gate: got tx_busy=%b before tx_wr expected 0", last_busy); end
      end
      wait_idle(50, ok);
   endtask

   task automatic test_protocol();
      n_vec++; if (wr_viol != 0) begin n_err++; $display("FAIL back_to_back_wr: got %0d expected 0", wr_viol); end
      n_vec++; if (ready_viol != 0) begin n_err++; $display("FAIL ready_vs_grant: got %0d expected 0", ready_viol); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_packet();
      test_nobusy();
      test_async_reset();
      test_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
